// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a scalar/vector pipeline: load-use stalls, multi-cycle
// vector occupancy of EX, taken-branch flushes, operand forwarding and stall statistics.
module pipeline_hazard_ctrl #(
    parameter int VEC_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       EX_rs1,
    input  logic [4:0]       EX_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RegWrite,
    input  logic             EX_VRegWrite,
    input  logic [1:0]       EX_MemToReg,
    input  logic [4:0]       MEM_rd,
    input  logic [4:0]       WB_rd,
    input  logic             MEM_RegWrite,
    input  logic             WB_RegWrite,
    input  logic             branch_taken,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             vbusy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, VBUSY, FLUSH} state_t;

    // The entry cycle in RUN plus VEC_LAT-1 cycles in VBUSY give VEC_LAT cycles in EX.
    localparam logic [3:0] VEC_LOAD = 4'(VEC_LAT - 2);

    state_t     state;
    logic [3:0] vec_cnt;
    logic       load_use;

    always_comb begin
        load_use = (EX_MemToReg == 2'b01) && EX_RegWrite && (EX_rd != 5'd0) && ID_valid &&
                   ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
    end

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (!rst) begin
            if (MEM_RegWrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rs1))
                fwdA = 2'b10;
            else if (WB_RegWrite && (WB_rd != 5'd0) && (WB_rd == EX_rs1))
                fwdA = 2'b01;
            if (MEM_RegWrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rs2))
                fwdB = 2'b10;
            else if (WB_RegWrite && (WB_rd != 5'd0) && (WB_rd == EX_rs2))
                fwdB = 2'b01;
        end
    end

    // Only the highest-priority event in RUN drives its controls; reset forces a bubble into EX.
    always_comb begin
        stall_IF = 1'b0;
        stall_ID = 1'b0;
        flush_ID = 1'b0;
        flush_EX = 1'b0;
        vbusy    = 1'b0;
        if (rst) begin
            flush_EX = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        flush_ID = 1'b1;
                        flush_EX = 1'b1;
                    end else if (EX_VRegWrite) begin
                        stall_IF = 1'b1;
                        stall_ID = 1'b1;
                    end else if (load_use) begin
                        stall_IF = 1'b1;
                        stall_ID = 1'b1;
                        flush_EX = 1'b1;
                    end
                end
                VBUSY: begin
                    vbusy    = 1'b1;
                    stall_IF = 1'b1;
                    stall_ID = 1'b1;
                end
                FLUSH: begin
                    flush_ID = 1'b1;
                end
                default: begin
                    flush_EX = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            vec_cnt   <= 4'd0;
            stall_cnt <= '0;
        end else begin
            if (stall_IF && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        state <= FLUSH;
                    end else if (EX_VRegWrite) begin
                        state   <= VBUSY;
                        vec_cnt <= VEC_LOAD;
                    end
                end
                VBUSY: begin
                    if (vec_cnt == 4'd0)
                        state <= RUN;
                    else
                        vec_cnt <= vec_cnt - 4'd1;
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter VEC_LAT, default 4: number of EX cycles a vector op (EX_VRegWrite=1) occupies, legal range 2..15.
REQ-002 Parameter CNT_W, default 16: width of the stall-statistics counter.
REQ-003 clk  in  1  pipeline clock; all state SHALL update on posedge clk only.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 ID_valid  in  1  ID stage holds a real instruction.
REQ-006 ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 EX_rs1, EX_rs2, EX_rd  in  5 each  register fields at the ID/EX register output.
REQ-008 EX_RegWrite, EX_VRegWrite  in  1 each  EX instruction writes the scalar or vector register file.
REQ-009 EX_MemToReg  in  2  EX writeback source; 2'b01 marks a load.
REQ-010 MEM_rd, WB_rd  in  5 each; MEM_RegWrite, WB_RegWrite  in  1 each  downstream destination info.
REQ-011 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-012 stall_IF, stall_ID  out  1 each  hold the PC and the IF/ID register.
REQ-013 flush_ID, flush_EX  out  1 each  zero the controls captured into IF/ID and ID/EX.
REQ-014 fwdA, fwdB  out  2 each  ALU operand select: 00 register file, 10 MEM result, 01 WB result.
REQ-015 vbusy  out  1  vector op occupying EX; stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-016 FSM states: RUN, VBUSY, FLUSH; encoding is free.
REQ-017 Load-use hazard (LU) SHALL be: EX_MemToReg==2'b01, EX_RegWrite=1, EX_rd!=0, ID_valid=1, and EX_rd equals ID_rs1 or ID_rs2.
REQ-018 RUN and LU asserted: stall_IF=stall_ID=flush_EX=1 in the same cycle (combinational); exactly one bubble per load because the load leaves EX on the next edge.
REQ-019 RUN and EX_VRegWrite=1 and not branch_taken: next state VBUSY, down-counter loaded with VEC_LAT-2.
REQ-020 VBUSY: vbusy=stall_IF=stall_ID=1, flush_EX=0 (ID/EX contents must be held by the caller); counter decrements each cycle; when it equals 0, next state RUN.
REQ-021 Total EX occupancy of a vector op SHALL be exactly VEC_LAT cycles, including the entry cycle in RUN.
REQ-022 branch_taken in RUN: flush_ID=flush_EX=1 combinationally, next state FLUSH; FLUSH asserts flush_ID=1 for one cycle, then returns to RUN.
REQ-023 Priority in RUN: branch_taken > vector entry > LU; only the winner's outputs are asserted.
REQ-024 branch_taken while in VBUSY or FLUSH SHALL be ignored.
REQ-025 Forwarding: fwdA=10 if MEM_RegWrite and MEM_rd!=0 and MEM_rd==EX_rs1; otherwise 01 if the same test on WB; otherwise 00. fwdB is identical using EX_rs2. MEM wins over WB.
REQ-026 Forwarding is purely combinational and active in every state; register x0 never forwards.
REQ-027 stall_cnt increments on every edge where stall_IF=1, and saturates at all-ones without wrapping.
REQ-028 All outputs other than fwdA/fwdB SHALL be glitch-free functions of state plus the inputs named above; the block has no hidden delay elements.

Reset
REQ-029 rst=1 at posedge: state=RUN, vector counter=0, stall_cnt=0; rst overrides every input in that cycle.
REQ-030 While rst=1: stall_IF, stall_ID, flush_ID, vbusy=0; flush_EX=1; fwdA=fwdB=00.
REQ-031 Reset asserted mid-VBUSY or mid-FLUSH SHALL abandon the operation; the first cycle after rst deasserts is RUN with no residual stall.

Verification
REQ-032 EX load rd=5, ID rs2=5, ID_valid=1 -> stall_IF/stall_ID/flush_EX high for exactly 1 cycle; stall_cnt 0->1.
REQ-033 EX_VRegWrite=1 with VEC_LAT=4 -> vbusy high 3 cycles, stall_IF high 4 cycles total, RUN on cycle 5; stall_cnt=4.
REQ-034 branch_taken and LU in the same cycle -> flush_ID=flush_EX=1, stall_IF=0; flush_ID also asserted on the next cycle; no load stall.
REQ-035 MEM_rd=WB_rd=7, both writing, EX_rs1=7 -> fwdA=10; MEM_RegWrite=0 -> fwdA=01; EX_rs1=0 -> fwdA=00.
REQ-036 rst pulsed on the 2nd VBUSY cycle -> stall_cnt=0, vbusy=0 next cycle, new load-use detected normally afterward.
REQ-037 CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.
